// File: rtl/rgb_pair_sram_writer.sv
// rgb_pair_sram_writer: takes even/odd RGB pixel pairs as signed fixed-point
// MAC accumulators and clips each channel to a byte. It packs the six bytes
// into three 16-bit words and writes them to SRAM one after another, starting
// at RGB_BASE.
module rgb_pair_sram_writer #(
   parameter logic [17:0] RGB_BASE  = 18'd146944,
   parameter int unsigned NUM_PAIRS = 38400,
   parameter int unsigned FRAC_BITS = 16
) (
   input  logic               Clock,
   input  logic               Resetn,
   input  logic               Start,
   input  logic signed [31:0] R_even,
   input  logic signed [31:0] G_even,
   input  logic signed [31:0] B_even,
   input  logic signed [31:0] R_odd,
   input  logic signed [31:0] G_odd,
   input  logic signed [31:0] B_odd,
   input  logic               Pair_valid,
   output logic               Pair_ready,
   output logic [17:0]        SRAM_address,
   output logic [15:0]        SRAM_write_data,
   output logic               SRAM_we_n,
   output logic               Busy,
   output logic               Done
);

   localparam int unsigned CNT_W = $clog2(NUM_PAIRS + 1);
   localparam logic [CNT_W-1:0] NUM_PAIRS_C = CNT_W'(NUM_PAIRS);
   // The first accumulator value that no longer fits in 8 integer bits.
   localparam logic signed [31:0] ACC_LIMIT = 32'sd256 <<< FRAC_BITS;

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_WAIT = 3'd1,
      S_W0   = 3'd2,
      S_W1   = 3'd3,
      S_W2   = 3'd4,
      S_DONE = 3'd5
   } state_t;

   // Saturate a signed accumulator to an unsigned byte. Negative values go to 0.
   // Values of 256 or more go to 255.
   function automatic logic [7:0] clip8(input logic signed [31:0] acc);
      logic [7:0] res;
      if (acc < 32'sd0) begin
         res = 8'd0;
      end else if (acc >= ACC_LIMIT) begin
         res = 8'd255;
      end else begin
         res = acc[FRAC_BITS +: 8];
      end
      return res;
   endfunction

   state_t           state_q;
   logic [17:0]      addr_cnt_q;
   logic [CNT_W-1:0] acc_cnt_q;
   logic [47:0]      pix_q;
   logic [17:0]      sram_address_q;
   logic [15:0]      sram_write_data_q;
   logic             sram_we_n_q;
   logic             busy_q;
   logic             done_q;

   logic [47:0]      pix_d;
   logic             pair_ready_s;
   logic             accept_s;

   // Clip all six channels and pack them in write order: {W0, W1, W2}.
   always_comb begin
      pix_d = {clip8(R_even), clip8(G_even), clip8(B_even),
               clip8(R_odd),  clip8(G_odd),  clip8(B_odd)};
   end

   // A pair can be taken while waiting, or during the last write of the
   // previous pair so that writes stay gapless, until the frame quota is met.
   always_comb begin
      pair_ready_s = 1'b0;
      if (((state_q == S_WAIT) || (state_q == S_W2)) && (acc_cnt_q < NUM_PAIRS_C)) begin
         pair_ready_s = 1'b1;
      end else begin
         pair_ready_s = 1'b0;
      end
   end

   assign accept_s        = Pair_valid & pair_ready_s;
   assign Pair_ready      = pair_ready_s;
   assign SRAM_address    = sram_address_q;
   assign SRAM_write_data = sram_write_data_q;
   assign SRAM_we_n       = sram_we_n_q;
   assign Busy            = busy_q;
   assign Done            = done_q;

   // Frame sequencer. It captures pairs and drives the registered SRAM write port.
   always_ff @(posedge Clock) begin
      if (!Resetn) begin
         state_q           <= S_IDLE;
         addr_cnt_q        <= 18'd0;
         acc_cnt_q         <= {CNT_W{1'b0}};
         pix_q             <= 48'd0;
         sram_address_q    <= 18'd0;
         sram_write_data_q <= 16'd0;
         sram_we_n_q       <= 1'b1;
         busy_q            <= 1'b0;
         done_q            <= 1'b0;
      end else begin
         case (state_q)
            S_IDLE, S_DONE: begin
               sram_we_n_q <= 1'b1;
               if (Start) begin
                  state_q    <= S_WAIT;
                  addr_cnt_q <= RGB_BASE;
                  acc_cnt_q  <= {CNT_W{1'b0}};
                  done_q     <= 1'b0;
                  busy_q     <= 1'b1;
               end else begin
                  state_q <= state_q;
               end
            end
            S_WAIT: begin
               sram_we_n_q <= 1'b1;
               if (accept_s) begin
                  pix_q     <= pix_d;
                  acc_cnt_q <= acc_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
                  state_q   <= S_W0;
               end else begin
                  state_q <= S_WAIT;
               end
            end
            S_W0: begin
               sram_we_n_q       <= 1'b0;
               sram_address_q    <= addr_cnt_q;
               sram_write_data_q <= pix_q[47:32];
               addr_cnt_q        <= addr_cnt_q + 18'd1;
               state_q           <= S_W1;
            end
            S_W1: begin
               sram_we_n_q       <= 1'b0;
               sram_address_q    <= addr_cnt_q;
               sram_write_data_q <= pix_q[31:16];
               addr_cnt_q        <= addr_cnt_q + 18'd1;
               state_q           <= S_W2;
            end
            S_W2: begin
               sram_we_n_q       <= 1'b0;
               sram_address_q    <= addr_cnt_q;
               sram_write_data_q <= pix_q[15:0];
               addr_cnt_q        <= addr_cnt_q + 18'd1;
               if (accept_s) begin
                  pix_q     <= pix_d;
                  acc_cnt_q <= acc_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
                  state_q   <= S_W0;
               end else if (acc_cnt_q == NUM_PAIRS_C) begin
                  state_q <= S_DONE;
                  busy_q  <= 1'b0;
                  done_q  <= 1'b1;
               end else begin
                  state_q <= S_WAIT;
               end
            end
            default: begin
               state_q     <= S_IDLE;
               sram_we_n_q <= 1'b1;
               busy_q      <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_rgb_pair_sram_writer.sv
// Directed testbench for rgb_pair_sram_writer. One instance uses the default
// frame size. A second instance with NUM_PAIRS=4 covers the end of a frame.
module tb_rgb_pair_sram_writer;

   localparam logic [17:0] BASE = 18'd146944;

   typedef struct {
      logic [31:0] r0, g0, b0, r1, g1, b1;
      logic [15:0] w0, w1, w2;
   } vec_t;

   logic        Clock = 1'b0;
   logic        Resetn = 1'b0;
   logic        Start = 1'b0;
   logic        Pair_valid = 1'b0;
   logic signed [31:0] r_even = 32'sd0, g_even = 32'sd0, b_even = 32'sd0;
   logic signed [31:0] r_odd = 32'sd0, g_odd = 32'sd0, b_odd = 32'sd0;

   logic        rdy, we_n, busy, done;
   logic [17:0] addr;
   logic [15:0] wdata;
   logic        rdy4, we_n4, busy4, done4;
   logic [17:0] addr4;
   logic [15:0] wdata4;

   int n_vec = 0;
   int n_err = 0;
   vec_t vecs[4];

   always #10 Clock = ~Clock;

   rgb_pair_sram_writer dut (
      .Clock(Clock), .Resetn(Resetn), .Start(Start),
      .R_even(r_even), .G_even(g_even), .B_even(b_even),
      .R_odd(r_odd), .G_odd(g_odd), .B_odd(b_odd),
      .Pair_valid(Pair_valid), .Pair_ready(rdy),
      .SRAM_address(addr), .SRAM_write_data(wdata), .SRAM_we_n(we_n),
      .Busy(busy), .Done(done)
   );

   rgb_pair_sram_writer #(.NUM_PAIRS(4)) dut4 (
      .Clock(Clock), .Resetn(Resetn), .Start(Start),
      .R_even(r_even), .G_even(g_even), .B_even(b_even),
      .R_odd(r_odd), .G_odd(g_odd), .B_odd(b_odd),
      .Pair_valid(Pair_valid), .Pair_ready(rdy4),
      .SRAM_address(addr4), .SRAM_write_data(wdata4), .SRAM_we_n(we_n4),
      .Busy(busy4), .Done(done4)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [15:0] wsel(input vec_t v, input int k);
      case (k)
         0:       return v.w0;
         1:       return v.w1;
         default: return v.w2;
      endcase
   endfunction

   task automatic set_pair(input vec_t v);
      r_even = v.r0; g_even = v.g0; b_even = v.b0;
      r_odd  = v.r1; g_odd  = v.g1; b_odd  = v.b1;
   endtask

   task automatic do_reset();
      Resetn = 1'b0; Start = 1'b0; Pair_valid = 1'b0;
      repeat (2) @(posedge Clock);
      @(negedge Clock);
      Resetn = 1'b1;
   endtask

   task automatic pulse_start();
      @(negedge Clock);
      Start = 1'b1;
      @(negedge Clock);
      Start = 1'b0;
   endtask

   // Offer one pair, wait (bounded) for acceptance, then check its three writes.
   task automatic drive_pair(input vec_t v, input logic [17:0] base_addr);
      bit got;
      got = 1'b0;
      @(negedge Clock);
      set_pair(v);
      Pair_valid = 1'b1;
      for (int i = 0; i < 20; i++) begin
         #1;
         if (rdy === 1'b1) begin
            got = 1'b1;
            break;
         end
         @(negedge Clock);
      end
      chk("accept_seen", {31'd0, got}, 32'd1);
      if (!got) begin
         Pair_valid = 1'b0;
         return;
      end
      @(posedge Clock);
      #1;
      Pair_valid = 1'b0;
      chk("accept_edge_we_n", {31'd0, we_n}, 32'd1);
      for (int k = 0; k < 3; k++) begin
         @(posedge Clock);
         #1;
         chk("pair_we_n", {31'd0, we_n}, 32'd0);
         chk("pair_addr", {14'd0, addr}, {14'd0, base_addr + 18'(k)});
         chk("pair_data", {16'd0, wdata}, {16'd0, wsel(v, k)});
      end
   endtask

   initial begin
      vecs[0] = '{32'hFFFF_FFFF, 32'h00FF_FFFF, 32'h0100_0000, 32'h0080_0000, 32'h7FFF_FFFF, 32'h8000_0000,
                  16'h00FF, 16'hFF80, 16'hFF00};
      vecs[1] = '{32'h0011_FFFF, 32'h0022_0000, 32'h0033_0000, 32'h0044_0000, 32'h0055_0000, 32'h0066_0000,
                  16'h1122, 16'h3344, 16'h5566};
      vecs[2] = '{32'h00AB_FFFF, 32'h0000_FFFF, 32'h00FF_FF00, 32'h0100_0001, 32'hFF00_0000, 32'h0001_7FFF,
                  16'hAB00, 16'hFFFF, 16'h0001};
      vecs[3] = '{32'h0000_0000, 32'h0001_0000, 32'h00FE_FFFF, 32'h0010_0000, 32'hFFFF_0000, 32'h0020_0000,
                  16'h0001, 16'hFE10, 16'h0020};

      // Reset state
      do_reset();
      #1;
      chk("rst_we_n", {31'd0, we_n}, 32'd1);
      chk("rst_addr", {14'd0, addr}, 32'd0);
      chk("rst_data", {16'd0, wdata}, 32'd0);
      chk("rst_ready", {31'd0, rdy}, 32'd0);
      chk("rst_busy", {31'd0, busy}, 32'd0);
      chk("rst_done", {31'd0, done}, 32'd0);

      // Table: clip and pack cases written back-to-back within one frame
      pulse_start();
      #1;
      chk("start_busy", {31'd0, busy}, 32'd1);
      for (int i = 0; i < 4; i++) begin
         drive_pair(vecs[i], BASE + 18'(3 * i));
      end
      @(posedge Clock);
      #1;
      chk("after_pairs_we_n", {31'd0, we_n}, 32'd1);
      chk("mid_frame_busy", {31'd0, busy}, 32'd1);
      chk("mid_frame_done", {31'd0, done}, 32'd0);

      // Back-to-back with Pair_valid held high, then a 5-cycle stall
      do_reset();
      pulse_start();
      set_pair(vecs[1]);
      for (int k = 0; k < 10; k++) begin
         @(negedge Clock);
         Pair_valid = (k < 9);
         #1;
         chk("b2b_ready", {31'd0, rdy}, {31'd0, (k % 3) == 0});
         @(posedge Clock);
         #1;
         if (k >= 1) begin
            chk("b2b_we_n", {31'd0, we_n}, 32'd0);
            chk("b2b_addr", {14'd0, addr}, {14'd0, BASE + 18'(k - 1)});
            chk("b2b_data", {16'd0, wdata}, {16'd0, wsel(vecs[1], (k - 1) % 3)});
         end else begin
            chk("b2b_first_we_n", {31'd0, we_n}, 32'd1);
         end
      end
      for (int s = 0; s < 5; s++) begin
         @(negedge Clock);
         Pair_valid = 1'b0;
         #1;
         chk("stall_ready", {31'd0, rdy}, 32'd1);
         @(posedge Clock);
         #1;
         chk("stall_we_n", {31'd0, we_n}, 32'd1);
         chk("stall_addr_hold", {14'd0, addr}, {14'd0, BASE + 18'd8});
      end
      drive_pair(vecs[2], BASE + 18'd9);

      // Frame end on the 4-pair instance, with a mid-frame Start that must be ignored
      do_reset();
      pulse_start();
      set_pair(vecs[3]);
      for (int k = 0; k < 13; k++) begin
         @(negedge Clock);
         Pair_valid = 1'b1;
         Start = (k == 5);
         #1;
         chk("fe_ready", {31'd0, rdy4}, {31'd0, ((k % 3) == 0) && (k < 12)});
         @(posedge Clock);
         #1;
         if (k >= 1) begin
            chk("fe_we_n", {31'd0, we_n4}, 32'd0);
            chk("fe_addr", {14'd0, addr4}, {14'd0, BASE + 18'(k - 1)});
            chk("fe_data", {16'd0, wdata4}, {16'd0, wsel(vecs[3], (k - 1) % 3)});
         end else begin
            chk("fe_first_we_n", {31'd0, we_n4}, 32'd1);
         end
         chk("fe_busy", {31'd0, busy4}, {31'd0, k < 12});
         chk("fe_done", {31'd0, done4}, {31'd0, k == 12});
      end
      @(negedge Clock);
      Start = 1'b0;
      Pair_valid = 1'b0;
      #1;
      chk("fe_done_ready", {31'd0, rdy4}, 32'd0);
      @(posedge Clock);
      #1;
      chk("fe_after_we_n", {31'd0, we_n4}, 32'd1);
      chk("fe_done_hold", {31'd0, done4}, 32'd1);
      chk("fe_addr_hold", {14'd0, addr4}, {14'd0, BASE + 18'd11});

      // Reset after two words of a pair, then restart the frame from the base address
      do_reset();
      pulse_start();
      @(negedge Clock);
      set_pair(vecs[1]);
      Pair_valid = 1'b1;
      @(posedge Clock);
      #1;
      Pair_valid = 1'b0;
      @(posedge Clock);
      @(posedge Clock);
      #1;
      chk("pre_rst_addr", {14'd0, addr}, {14'd0, BASE + 18'd1});
      Resetn = 1'b0;
      @(posedge Clock);
      #1;
      chk("mid_rst_we_n", {31'd0, we_n}, 32'd1);
      chk("mid_rst_addr", {14'd0, addr}, 32'd0);
      chk("mid_rst_data", {16'd0, wdata}, 32'd0);
      chk("mid_rst_ready", {31'd0, rdy}, 32'd0);
      chk("mid_rst_busy", {31'd0, busy}, 32'd0);
      chk("mid_rst_done", {31'd0, done}, 32'd0);
      @(negedge Clock);
      Resetn = 1'b1;
      pulse_start();
      drive_pair(vecs[1], BASE);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
